// File: rtl/act_pkg.sv
// Shared types and default widths for the activation scheduler.
package act_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam int INBITS_DEF  = 8;
   localparam int OUTBITS_DEF = 8;

endpackage

// File: rtl/act_scheduler_if.sv
// Activation buffer port: read strobe/address/data plus in-place write.
interface act_buf_if
   import act_pkg::*;
#(
   parameter int INBITS  = INBITS_DEF,
   parameter int OUTBITS = OUTBITS_DEF,
   parameter int ADDRW   = 8
);

   logic                      rd_en;
   logic [ADDRW-1:0]          rd_addr;
   logic signed [INBITS-1:0]  rd_data;
   logic                      wr_en;
   logic [ADDRW-1:0]          wr_addr;
   logic [OUTBITS-1:0]        wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data
   );

endinterface

// File: rtl/act_scheduler_relu_requant.sv
// ReLU + arithmetic right shift, one register stage.
// ACT_SAT_EN: clamp to the signed output max instead of truncating.
module relu_requant
   import act_pkg::*;
#(
   parameter int INBITS  = INBITS_DEF,
   parameter int OUTBITS = OUTBITS_DEF,
   parameter int SHW     = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [INBITS-1:0] x,
   input  logic [SHW-1:0]           sh,
   output logic                     out_valid,
   output logic [OUTBITS-1:0]       y
);

   localparam int W = (INBITS > OUTBITS) ? INBITS : OUTBITS;
   localparam logic [W-1:0] MAXV =
      {{(W-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};

   logic [W-1:0]       t;
   logic [OUTBITS-1:0] a;

   always_comb begin
      t = '0;
      if (!x[INBITS-1]) t = W'($unsigned(x)) >> sh;
`ifdef ACT_SAT_EN
      if (t > MAXV) t = MAXV;
`else
`endif
      a = t[OUTBITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) y <= a;
      end
   end

endmodule

// File: rtl/act_scheduler.sv
// Round-robin owner of the shared ReLU/requant path over the act buffer.
// ACT_SAT_EN selects saturating write-back in relu_requant.
module act_scheduler
   import act_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int INBITS  = INBITS_DEF,
   parameter int OUTBITS = OUTBITS_DEF,
   parameter int ADDRW   = 8,
   parameter int LENW    = 8,
   parameter int SHW     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*ADDRW-1:0] base,
   input  logic [NREQ*LENW-1:0]  len,
   input  logic [NREQ*SHW-1:0]   shift,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   act_buf_if.master             abuf
);

   localparam int PW = $clog2(NREQ);

   state_e state_q, state_d;

   logic [PW-1:0]    rr_q, owner_q, pick;
   logic             found;
   logic [ADDRW-1:0] base_q, ra_q, wa_q;
   logic [LENW-1:0]  len_q, k_q;
   logic [SHW-1:0]   shift_q;
   logic             rv_q, wv;
   logic [OUTBITS-1:0] wd;

   always_comb begin : arb
      int j;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(rr_q) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = GRANT;
         GRANT:   state_d = (len_q == '0) ? DONE : RUN;
         RUN:     if (k_q == len_q - LENW'(1)) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q != IDLE);
      gnt          = busy ? (NREQ'(1) << owner_q) : '0;
      done         = (state_q == DONE) ? (NREQ'(1) << owner_q) : '0;
      abuf.rd_en   = (state_q == RUN);
      abuf.rd_addr = abuf.rd_en ? base_q + ADDRW'(k_q) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         base_q  <= '0;
         len_q   <= '0;
         shift_q <= '0;
         k_q     <= '0;
         rv_q    <= 1'b0;
         ra_q    <= '0;
         wa_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && found) begin
            owner_q <= pick;
            base_q  <= base[int'(pick)*ADDRW +: ADDRW];
            len_q   <= len[int'(pick)*LENW +: LENW];
            shift_q <= shift[int'(pick)*SHW +: SHW];
         end
         if (state_q == GRANT) k_q <= '0;
         else if (state_q == RUN) k_q <= k_q + LENW'(1);
         if (state_q == DONE)
            rr_q <= (owner_q == PW'(NREQ-1)) ? '0 : owner_q + PW'(1);
         // read data lands one cycle after the strobe; track its address
         rv_q <= abuf.rd_en;
         ra_q <= abuf.rd_addr;
         wa_q <= ra_q;
      end
   end

   relu_requant #(
      .INBITS  (INBITS),
      .OUTBITS (OUTBITS),
      .SHW     (SHW)
   ) u_act (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rv_q),
      .x         (abuf.rd_data),
      .sh        (shift_q),
      .out_valid (wv),
      .y         (wd)
   );

   assign abuf.wr_en   = wv;
   assign abuf.wr_addr = wa_q;
   assign abuf.wr_data = wd;

endmodule

// File: tb/tb_act_scheduler.sv
// Directed bench for act_scheduler with a small buffer model.
module tb_act_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  req;
   logic [15:0] base, len;
   logic [5:0]  shift;
   logic [1:0]  gnt, done;
   logic        busy;

   act_buf_if #(.INBITS(8), .OUTBITS(8), .ADDRW(8)) bus ();

   act_scheduler #(
      .NREQ(2), .INBITS(8), .OUTBITS(8),
      .ADDRW(8), .LENW(8), .SHW(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .base  (base),
      .len   (len),
      .shift (shift),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .abuf  (bus)
   );

   logic       rq_v, rq_ov;
   logic [7:0] rq_x;
   logic [2:0] rq_sh;
   logic [3:0] rq_y;

   relu_requant #(.INBITS(8), .OUTBITS(4), .SHW(3)) u_rq (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rq_v),
      .x         (rq_x),
      .sh        (rq_sh),
      .out_valid (rq_ov),
      .y         (rq_y)
   );

`ifdef ACT_SAT_EN
   localparam logic [3:0] E100S2 = 4'd7;
   localparam logic [3:0] E100S0 = 4'd7;
`else
   localparam logic [3:0] E100S2 = 4'd9;
   localparam logic [3:0] E100S0 = 4'd4;
`endif

   logic [7:0] src [256];
   logic [7:0] dst [256];
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
   int bad_gnt = 0, bad_done = 0;
   logic [1:0] prev_done = 2'b00;
   int errors = 0, checks = 0;

   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
      if (bus.wr_en) dst[bus.wr_addr] <= bus.wr_data;
      rd_cnt   <= rd_cnt + (bus.rd_en ? 1 : 0);
      wr_cnt   <= wr_cnt + (bus.wr_en ? 1 : 0);
      done_cnt <= done_cnt + ((done != 2'b00) ? 1 : 0);
      bad_gnt  <= bad_gnt + ((gnt == 2'b11) ? 1 : 0);
      bad_done <= bad_done + (((done & prev_done) != 2'b00) ? 1 : 0);
      prev_done <= done;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_rden"}, 32'(bus.rd_en), 0);
      check({tag, "_rdaddr"}, 32'(bus.rd_addr), 0);
      check({tag, "_wren"}, 32'(bus.wr_en), 0);
      check({tag, "_wraddr"}, 32'(bus.wr_addr), 0);
      check({tag, "_wrdata"}, 32'(bus.wr_data), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n, k, r0, w0, d0, g0, b0;
      logic [1:0] seq [4];
      logic [7:0] adr [3];
      req = 0; base = 0; len = 0; shift = 0;
      rq_v = 0; rq_x = 0; rq_sh = 0;
      for (int i = 0; i < 4; i++) seq[i] = 2'b00;
      for (int i = 0; i < 3; i++) adr[i] = 8'h55;
      for (int i = 0; i < 256; i++) src[i] = 8'h00;
      src[8'h10] = 8'hFD; src[8'h11] = 8'd5;
      src[8'h12] = 8'd0;  src[8'h13] = 8'd127;
      src[8'h60] = 8'd9;
      src[8'hFE] = 8'd64; src[8'hFF] = 8'hFF; src[8'h00] = 8'd33;
      @(negedge clk);
      tick(); tick();
      check_idle("rst");
      reset = 0;

      // single requester, mixed sign data
      base[7:0] = 8'h10; len[7:0] = 8'd4; shift[2:0] = 3'd0;
      r0 = rd_cnt; w0 = wr_cnt;
      req = 2'b01;
      tick(); n = 1;
      check("t1_gnt", 32'(gnt), 32'h1);
      while (done == 0 && n < 20) begin tick(); n++; end
      check("t1_done", 32'(done), 32'h1);
      check("t1_lat", 32'(n), 32'd7);
      req = 0;
      tick();
      check("t1_m10", 32'(dst[8'h10]), 32'h00);
      check("t1_m11", 32'(dst[8'h11]), 32'h05);
      check("t1_m12", 32'(dst[8'h12]), 32'h00);
      check("t1_m13", 32'(dst[8'h13]), 32'h7F);
      check("t1_rds", 32'(rd_cnt - r0), 32'd4);
      check("t1_wrs", 32'(wr_cnt - w0), 32'd4);
      check("t1_idle", 32'(busy), 32'h0);

      // two requesters held: strict alternation
      reset = 1; tick(); reset = 0;
      base = {8'h40, 8'h20}; len = {8'd2, 8'd2};
      g0 = bad_gnt; b0 = bad_done;
      req = 2'b11; k = 0; n = 0;
      while (k < 4 && n < 60) begin
         tick(); n++;
         if (done != 0) begin seq[k] = done; k++; end
      end
      req = 0;
      tick();
      check("t2_o0", 32'(seq[0]), 32'h1);
      check("t2_o1", 32'(seq[1]), 32'h2);
      check("t2_o2", 32'(seq[2]), 32'h1);
      check("t2_o3", 32'(seq[3]), 32'h2);
      check("t2_gnt11", 32'(bad_gnt - g0), 32'd0);
      check("t2_pulse", 32'(bad_done - b0), 32'd0);

      // zero-length vector
      len[7:0] = 8'd0;
      r0 = rd_cnt; w0 = wr_cnt;
      req = 2'b01;
      tick(); n = 1;
      check("t3_gnt", 32'(gnt), 32'h1);
      while (done == 0 && n < 20) begin tick(); n++; end
      check("t3_done", 32'(done), 32'h1);
      check("t3_lat", 32'(n), 32'd2);
      req = 0;
      tick();
      check("t3_rds", 32'(rd_cnt - r0), 32'd0);
      check("t3_wrs", 32'(wr_cnt - w0), 32'd0);

      // activation function on a 4-bit output instance
      rq_v = 1; rq_x = 8'd100; rq_sh = 3'd2;
      tick();
      check("t4_vld", 32'(rq_ov), 32'h1);
      check("t4_100s2", 32'(rq_y), 32'(E100S2));
      rq_x = 8'hFB; rq_sh = 3'd0;
      tick();
      check("t4_neg", 32'(rq_y), 32'h0);
      rq_x = 8'd100; rq_sh = 3'd0;
      tick();
      check("t4_100s0", 32'(rq_y), 32'(E100S0));
      rq_x = 8'd20; rq_sh = 3'd2;
      tick();
      check("t4_20s2", 32'(rq_y), 32'h5);
      rq_v = 0;

      // reset in the middle of a run
      base[7:0] = 8'h60; len[7:0] = 8'd6; shift[2:0] = 3'd0;
      r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      req = 2'b01; n = 0;
      while (!(bus.rd_en && bus.rd_addr == 8'h62) && n < 20) begin
         tick(); n++;
      end
      check("t5_k2", 32'(bus.rd_addr), 32'h62);
      reset = 1;
      tick();
      check_idle("t5");
      reset = 0;
      check("t5_nodone", 32'(done_cnt - d0), 32'd0);
      check("t5_rds", 32'(rd_cnt - r0), 32'd3);
      check("t5_wrs", 32'(wr_cnt - w0), 32'd1);
      check("t5_m60", 32'(dst[8'h60]), 32'h09);
      req = 2'b11;
      tick(); n = 1;
      check("t5_rr0", 32'(gnt), 32'h1);
      while (done == 0 && n < 30) begin tick(); n++; end
      check("t5_done", 32'(done), 32'h1);
      req = 0;
      tick();

      // address wrap, request dropped mid-run
      base[15:8] = 8'hFE; len[15:8] = 8'd3; shift[5:3] = 3'd1;
      req = 2'b10; k = 0; n = 0;
      while (k < 3 && n < 20) begin
         tick(); n++;
         if (bus.rd_en) begin adr[k] = bus.rd_addr; k++; req = 0; end
      end
      check("t6_a0", 32'(adr[0]), 32'hFE);
      check("t6_a1", 32'(adr[1]), 32'hFF);
      check("t6_a2", 32'(adr[2]), 32'h00);
      while (done == 0 && n < 30) begin tick(); n++; end
      check("t6_done", 32'(done), 32'h2);
      tick();
      check("t6_mFE", 32'(dst[8'hFE]), 32'd32);
      check("t6_mFF", 32'(dst[8'hFF]), 32'd0);
      check("t6_m00", 32'(dst[8'h00]), 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
